// File: rtl/match_sequencer.sv
// match_sequencer: game-phase controller owning match countdown, scores and ball freeze/reset controls
module match_sequencer #(
   parameter int CLK_TICKS_PER_SEC  = 50000000,
   parameter int MATCH_SECONDS      = 180,
   parameter int GOAL_PAUSE_SECONDS = 2,
   parameter int SCORE_MAX          = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] buttons_n,
   input  logic       blue_score_tgl,
   input  logic       red_score_tgl,
   output logic       game_initiated,
   output logic       ball_reset,
   output logic       ball_freeze,
   output logic       game_over,
   output logic [7:0] time_left,
   output logic [6:0] blue_score,
   output logic [6:0] red_score,
   output logic [1:0] winner,
   output logic [2:0] phase
);
   localparam int TW = CLK_TICKS_PER_SEC > 1 ? $clog2(CLK_TICKS_PER_SEC) : 1;
   localparam int PW = $clog2(GOAL_PAUSE_SECONDS + 1);
   typedef enum logic [2:0] {IDLE = 3'd0, KICKOFF = 3'd1, PLAY = 3'd2, GOAL_PAUSE = 3'd3, OVER = 3'd4} state_t;
   state_t state;
   logic [TW-1:0] tick_cnt;
   logic [PW-1:0] pause_cnt;
   logic hist_valid, blue_hist, red_hist;
   logic running, sec_tick, blue_goal, red_goal, time_out;
   logic [6:0] blue_nxt, red_nxt;
   logic [7:0] time_nxt;
   assign phase = state;
   always_comb begin
      running   = state == PLAY || state == GOAL_PAUSE;
      sec_tick  = running && tick_cnt == TW'(CLK_TICKS_PER_SEC - 1);
      blue_goal = state == PLAY && hist_valid && blue_score_tgl != blue_hist;
      red_goal  = state == PLAY && hist_valid && red_score_tgl != red_hist;
      blue_nxt  = blue_goal && blue_score != 7'(SCORE_MAX) ? blue_score + 7'd1 : blue_score;
      red_nxt   = red_goal && red_score != 7'(SCORE_MAX) ? red_score + 7'd1 : red_score;
      time_nxt  = sec_tick && time_left != 8'd0 ? time_left - 8'd1 : time_left;
      time_out  = running && time_nxt == 8'd0;
   end
   // A final-second goal is already folded into *_nxt, so the latched winner includes it.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state          <= IDLE;
         game_initiated <= 1'b0;
         ball_reset     <= 1'b0;
         ball_freeze    <= 1'b1;
         game_over      <= 1'b0;
         time_left      <= 8'(MATCH_SECONDS);
         blue_score     <= '0;
         red_score      <= '0;
         winner         <= 2'b00;
         tick_cnt       <= '0;
         pause_cnt      <= '0;
         hist_valid     <= 1'b0;
         blue_hist      <= 1'b0;
         red_hist       <= 1'b0;
      end else begin
         hist_valid <= 1'b1;
         blue_hist  <= blue_score_tgl;
         red_hist   <= red_score_tgl;
         blue_score <= blue_nxt;
         red_score  <= red_nxt;
         time_left  <= time_nxt;
         ball_reset <= 1'b0;
         if (running) tick_cnt <= sec_tick ? '0 : tick_cnt + 1'b1;
         case (state)
            IDLE:
               if (~&buttons_n) begin
                  state          <= KICKOFF;
                  tick_cnt       <= '0;
                  ball_reset     <= 1'b1;
                  game_initiated <= 1'b1;
                  ball_freeze    <= 1'b0;
               end
            KICKOFF: state <= PLAY;
            PLAY, GOAL_PAUSE:
               if (time_out) begin
                  state       <= OVER;
                  game_over   <= 1'b1;
                  ball_freeze <= 1'b1;
                  winner      <= blue_nxt > red_nxt ? 2'b01 : red_nxt > blue_nxt ? 2'b10 : 2'b00;
               end else if (state == PLAY && (blue_goal || red_goal)) begin
                  state       <= GOAL_PAUSE;
                  pause_cnt   <= PW'(GOAL_PAUSE_SECONDS);
                  ball_freeze <= 1'b1;
               end else if (state == GOAL_PAUSE && sec_tick) begin
                  pause_cnt <= pause_cnt - 1'b1;
                  if (pause_cnt == PW'(1)) begin
                     state       <= PLAY;
                     ball_reset  <= 1'b1;
                     ball_freeze <= 1'b0;
                  end
               end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed and randomized checks of match_sequencer against a rule-level model
module tb_match_sequencer;
   localparam int TICKS = 10, MATCH = 3, PAUSE = 1, SMAX = 2;
   logic       clk = 1'b0, rst = 1'b1;
   logic [7:0] buttons_n = 8'hFF;
   logic       blue_score_tgl = 1'b0, red_score_tgl = 1'b0;
   logic       game_initiated, ball_reset, ball_freeze, game_over;
   logic [7:0] time_left;
   logic [6:0] blue_score, red_score;
   logic [1:0] winner;
   logic [2:0] phase;
   int passed = 0, total = 0;
   int m_phase, m_cnt, m_time, m_blue, m_red, m_pause;
   bit m_hv, m_bh, m_rh, m_br;

   match_sequencer #(.CLK_TICKS_PER_SEC(TICKS), .MATCH_SECONDS(MATCH),
                     .GOAL_PAUSE_SECONDS(PAUSE), .SCORE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst), .buttons_n(buttons_n),
      .blue_score_tgl(blue_score_tgl), .red_score_tgl(red_score_tgl),
      .game_initiated(game_initiated), .ball_reset(ball_reset), .ball_freeze(ball_freeze),
      .game_over(game_over), .time_left(time_left), .blue_score(blue_score),
      .red_score(red_score), .winner(winner), .phase(phase));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_time = MATCH; m_blue = 0; m_red = 0; m_pause = 0;
      m_hv = 0; m_bh = 0; m_rh = 0; m_br = 0;
   endtask

   // One clock edge of the match rules, in plain arithmetic.
   task automatic model_edge(input logic [7:0] b, input bit bt, input bit rt);
      bit play, tick, bg, rg;
      int nt;
      if (rst) begin model_reset(); return; end
      play = m_phase == 2 || m_phase == 3;
      tick = play && m_cnt == TICKS - 1;
      bg = m_phase == 2 && m_hv && bt != m_bh;
      rg = m_phase == 2 && m_hv && rt != m_rh;
      nt = (tick && m_time > 0) ? m_time - 1 : m_time;
      m_hv = 1; m_bh = bt; m_rh = rt; m_br = 0;
      if (bg) m_blue = (m_blue + 1 > SMAX) ? SMAX : m_blue + 1;
      if (rg) m_red = (m_red + 1 > SMAX) ? SMAX : m_red + 1;
      if (play) m_cnt = tick ? 0 : m_cnt + 1;
      m_time = nt;
      if (m_phase == 0) begin
         if (b != 8'hFF) begin m_phase = 1; m_cnt = 0; m_br = 1; end
      end else if (m_phase == 1) m_phase = 2;
      else if (play && m_time == 0) m_phase = 4;
      else if (m_phase == 2 && (bg || rg)) begin m_phase = 3; m_pause = PAUSE; end
      else if (m_phase == 3 && tick) begin
         m_pause--;
         if (m_pause == 0) begin m_phase = 2; m_br = 1; end
      end
   endtask

   task automatic check_all(input string tag);
      int w;
      w = m_phase != 4 ? 0 : m_blue > m_red ? 1 : m_red > m_blue ? 2 : 0;
      chk({tag, ".phase"}, 8'(phase), 8'(m_phase));
      chk({tag, ".time_left"}, time_left, 8'(m_time));
      chk({tag, ".blue_score"}, 8'(blue_score), 8'(m_blue));
      chk({tag, ".red_score"}, 8'(red_score), 8'(m_red));
      chk({tag, ".game_over"}, 8'(game_over), 8'(m_phase == 4));
      chk({tag, ".ball_freeze"}, 8'(ball_freeze), 8'(m_phase == 0 || m_phase >= 3));
      chk({tag, ".game_initiated"}, 8'(game_initiated), 8'(m_phase != 0));
      chk({tag, ".ball_reset"}, 8'(ball_reset), 8'(m_br));
      chk({tag, ".winner"}, 8'(winner), 8'(w));
   endtask

   task automatic cyc(input string tag, input logic [7:0] b, input bit fb, input bit fr);
      buttons_n = b;
      blue_score_tgl = blue_score_tgl ^ fb;
      red_score_tgl = red_score_tgl ^ fr;
      @(posedge clk);
      model_edge(b, blue_score_tgl, red_score_tgl);
      #1 check_all(tag);
   endtask

   // Called at posedge+1: raises rst mid-cycle, checks immediately, holds through one edge.
   task automatic async_reset(input string tag);
      #3 rst = 1'b1;
      model_reset();
      #1 check_all(tag);
      cyc(tag, 8'hFF, 0, 0);
      rst = 1'b0;
   endtask

   task automatic kickoff(input string tag);
      cyc(tag, 8'hFE, 0, 0);
      cyc(tag, 8'hFF, 0, 0);
   endtask

   initial begin
      bit found;
      model_reset();
      cyc("reset", 8'hFF, 0, 0);
      cyc("reset", 8'hFF, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) cyc("idle", 8'hFF, 0, 0);
      kickoff("kickoff");
      for (int i = 0; i < 35; i++) cyc("countdown", 8'hFF, 0, 0);
      chk("countdown_over", 8'(phase), 8'd4);
      async_reset("rst_after_over");
      kickoff("kickoff2");
      for (int i = 0; i < 3; i++) cyc("play", 8'hFF, 0, 0);
      cyc("blue_goal", 8'hFF, 1, 0);
      chk("blue_goal_pause", 8'(phase), 8'd3);
      for (int i = 0; i < 12; i++) cyc("pause", 8'hFF, 0, 0);
      cyc("both_goals", 8'hFF, 1, 1);
      cyc("pause_red", 8'hFF, 0, 1);
      for (int i = 0; i < 30; i++) cyc("run_out", 8'hFF, 0, 0);
      async_reset("rst_final");
      kickoff("kickoff3");
      found = 0;
      for (int i = 0; i < 100 && !found; i++)
         if (m_phase == 2 && m_time == 1 && m_cnt == TICKS - 1) found = 1;
         else cyc("to_final", 8'hFF, 0, 0);
      chk("final_tick_reached", 8'(found), 8'd1);
      cyc("final_goal", 8'hFF, 0, 1);
      chk("final_goal_winner", 8'(winner), 8'd2);
      async_reset("rst_mid_pause_pre");
      kickoff("kickoff4");
      cyc("goal4", 8'hFF, 1, 0);
      cyc("in_pause", 8'hFF, 0, 0);
      chk("in_pause_phase", 8'(phase), 8'd3);
      async_reset("rst_mid_pause");
      cyc("first_after_rst", 8'hFE, 1, 1);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
         else cyc("rand", ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
         if (m_phase == 4 && $urandom_range(0, 9) == 0) async_reset("rand_over_rst");
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
